key_press_capture: RTL and testbench

// - Front end for the four note keys: synchronises raw active-low KEY pins, debounces each key, turns a

---
 rtl/game_pkg.sv | 14 +
 rtl/key_debouncer.sv | 45 ++++
 rtl/key_press_capture.sv | 90 +++++++++
 tb/tb_key_press_capture.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared constants for the note-key front end: key count, capture FSM encodings
// and the default debounce interval.
package game_pkg;

  localparam int NUM_KEYS            = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 500000;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_ACK     = 2'd1,
    WAIT_RELEASE = 2'd2
  } cap_state_t;

endpackage

// File: rtl/key_debouncer.sv
// One key: 2-flop synchroniser on the raw active-low pin, then a stability counter
// that flips the debounced level only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic key_down
);

  logic             key_n_sync1;
  logic             key_n_sync2;
  logic             pressed_s;
  logic [CNT_W-1:0] cnt;

  assign pressed_s = ~key_n_sync2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_n_sync1 <= 1'b1;
      key_n_sync2 <= 1'b1;
    end else begin
      key_n_sync1 <= key_n;
      key_n_sync2 <= key_n_sync1;
    end
  end

  // The counter clears at the terminal count, so it can never exceed DEBOUNCE_CYCLES-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      key_down <= 1'b0;
    end else if (pressed_s == key_down) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      cnt      <= '0;
      key_down <= ~key_down;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/key_press_capture.sv
// Note-key front end: debounces each key, captures one press edge as a note,
// holds it until acknowledged and requires all keys released before the next capture.
module key_press_capture #(
  parameter int NUM_KEYS        = game_pkg::NUM_KEYS,
  parameter int DEBOUNCE_CYCLES = game_pkg::DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic                accept_en,
  input  logic                note_ack,
  input  logic                clear_overrun,
  output logic [NUM_KEYS-1:0] note,
  output logic                note_valid,
  output logic [NUM_KEYS-1:0] key_down,
  output logic                overrun
);
  import game_pkg::*;

  cap_state_t          state;
  logic [NUM_KEYS-1:0] key_down_q;
  logic [NUM_KEYS-1:0] rise;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_deb (
      .clk      (clk),
      .reset    (reset),
      .key_n    (key_n[i]),
      .key_down (key_down[i])
    );
  end

  assign rise = key_down & ~key_down_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_down_q <= '0;
    end else begin
      key_down_q <= key_down;
    end
  end

  // overrun: clear first so a same-cycle set (later assignment) wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      note       <= '0;
      note_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (clear_overrun) begin
        overrun <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (accept_en && (|rise)) begin
            note       <= rise;
            note_valid <= 1'b1;
            state      <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (|rise) begin
            overrun <= 1'b1;
          end
          if (note_ack) begin
            note       <= '0;
            note_valid <= 1'b0;
            state      <= (|key_down) ? WAIT_RELEASE : IDLE;
          end
        end
        WAIT_RELEASE: begin
          if (key_down == '0) begin
            state <= IDLE;
          end
        end
        default: begin
          note       <= '0;
          note_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_press_capture.sv
// Directed bench for key_press_capture with a short debounce interval; expected notes
// are queued when presses are driven and compared when note_valid appears.
module tb_key_press_capture;

  localparam int NK = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NK-1:0] key_n;
  logic          accept_en;
  logic          note_ack;
  logic          clear_overrun;
  logic [NK-1:0] note;
  logic          note_valid;
  logic [NK-1:0] key_down;
  logic          overrun;

  int n_total  = 0;
  int n_passed = 0;
  logic [NK-1:0] exp_q[$];

  key_press_capture #(
    .NUM_KEYS        (NK),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .key_n         (key_n),
    .accept_en     (accept_en),
    .note_ack      (note_ack),
    .clear_overrun (clear_overrun),
    .note          (note),
    .note_valid    (note_valid),
    .key_down      (key_down),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_note(input string tag, input int max_cycles);
    bit            seen;
    logic [NK-1:0] e;
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(negedge clk);
      if (note_valid === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      chk({tag, "_timeout"}, 32'(note_valid), 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(note), 32'(e));
    end
  endtask

  task automatic ack_pulse();
    note_ack = 1'b1;
    tick(1);
    note_ack = 1'b0;
  endtask

  initial begin
    bit bounce_seen;
    reset = 1'b0; key_n = '1; accept_en = 1'b0; note_ack = 1'b0; clear_overrun = 1'b0;
    tick(2);
    chk("rst_note_valid", 32'(note_valid), 32'd0);
    chk("rst_note",       32'(note),       32'd0);
    chk("rst_key_down",   32'(key_down),   32'd0);
    chk("rst_overrun",    32'(overrun),    32'd0);
    reset = 1'b1;
    tick(2);

    // Clean press: key_down after 6 edges, note on the 7th.
    accept_en = 1'b1;
    key_n = 4'b1110;
    exp_q.push_back(4'b0001);
    tick(5);
    chk("clean_kd_edge5", 32'(key_down), 32'd0);
    tick(1);
    chk("clean_kd_edge6", 32'(key_down), 32'h1);
    chk("clean_nv_edge6", 32'(note_valid), 32'd0);
    tick(1);
    chk("clean_nv_edge7", 32'(note_valid), 32'd1);
    chk("clean_note", 32'(note), 32'(exp_q.pop_front()));

    // Overrun while the note is pending.
    key_n = 4'b0110;
    tick(8);
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_note_held", 32'(note), 32'h1);
    chk("ovr_nv_held", 32'(note_valid), 32'd1);
    clear_overrun = 1'b1;
    tick(1);
    clear_overrun = 1'b0;
    chk("ovr_cleared", 32'(overrun), 32'd0);

    // Handshake with keys still held: no second note.
    ack_pulse();
    chk("ack_nv", 32'(note_valid), 32'd0);
    chk("ack_note", 32'(note), 32'd0);
    tick(10);
    chk("held_no_renote", 32'(note_valid), 32'd0);
    key_n = '1;
    tick(8);
    chk("release_kd", 32'(key_down), 32'd0);
    key_n = 4'b1011;
    exp_q.push_back(4'b0100);
    wait_note("key2_note", 12);
    ack_pulse();
    key_n = '1;
    tick(8);

    // Bounce on key1 must be filtered entirely.
    bounce_seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      key_n[1] = ((t / 2) % 2 == 0) ? 1'b0 : 1'b1;
      tick(1);
      if (key_down !== 4'b0000 || note_valid !== 1'b0) bounce_seen = 1'b1;
    end
    key_n = '1;
    tick(8);
    chk("bounce_no_activity", 32'(bounce_seen), 32'd0);
    chk("bounce_kd", 32'(key_down), 32'd0);
    chk("bounce_nv", 32'(note_valid), 32'd0);

    // Simultaneous press -> multi-hot note.
    key_n = 4'b1010;
    exp_q.push_back(4'b0101);
    wait_note("simul_note", 12);
    ack_pulse();
    key_n = '1;
    tick(8);

    // Same press with capture disabled.
    accept_en = 1'b0;
    key_n = 4'b1010;
    tick(10);
    chk("noaccept_kd", 32'(key_down), 32'h5);
    chk("noaccept_nv", 32'(note_valid), 32'd0);
    key_n = '1;
    tick(8);
    accept_en = 1'b1;

    // Async reset in WAIT_ACK with overrun set, between clock edges.
    key_n = 4'b1110;
    exp_q.push_back(4'b0001);
    wait_note("pre_reset_note", 12);
    key_n = 4'b0110;
    tick(8);
    chk("pre_reset_ovr", 32'(overrun), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_nv", 32'(note_valid), 32'd0);
    chk("async_note", 32'(note), 32'd0);
    chk("async_kd", 32'(key_down), 32'd0);
    chk("async_ovr", 32'(overrun), 32'd0);
    tick(2);
    reset = 1'b1;

    // Keys held through reset register as one press.
    exp_q.push_back(4'b1001);
    wait_note("held_thru_reset", 12);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
